// File: rtl/psg_bus_controller_if.sv
// psg_bus_controller_if: host write handshake and PSG control register bus
interface psg_bus_controller_if;
  logic        wr;
  logic [7:0]  data;
  logic        ready;
  logic [15:0] attn;
  logic [29:0] tone_freq;
  logic [2:0]  noise_ctrl;
  logic        noise_reset;
  modport master (output wr, data, input ready, attn, tone_freq, noise_ctrl, noise_reset);
  modport slave (input wr, data, output ready, attn, tone_freq, noise_ctrl, noise_reset);
endinterface

// File: rtl/psg_bus_controller.sv
// psg_bus_controller: SN76489 latch/data byte decoder owning all PSG control registers
module psg_bus_controller #(
  parameter int         WRITE_CYCLES = 4,
  parameter logic [3:0] RESET_ATTN   = 4'hF
) (
  input logic                 clk,
  input logic                 reset,
  psg_bus_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, APPLY, WAIT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] attn_q, attn_d;
  logic [29:0] tone_q, tone_d;
  logic [2:0]  noise_q, noise_d;
  logic        nrst_q, nrst_d;
  logic [1:0]  ch;
  logic        vol;
  assign ch  = hold_q[7] ? hold_q[6:5] : ptr_q[2:1];
  assign vol = hold_q[7] ? hold_q[4] : ptr_q[0];
  assign bus.ready       = state_q == IDLE;
  assign bus.attn        = attn_q;
  assign bus.tone_freq   = tone_q;
  assign bus.noise_ctrl  = noise_q;
  assign bus.noise_reset = nrst_q;
  // state and control registers; reset discards any write in flight
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      attn_q  <= {4{RESET_ATTN}};
      tone_q  <= '0;
      noise_q <= '0;
      nrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      attn_q  <= attn_d;
      tone_q  <= tone_d;
      noise_q <= noise_d;
      nrst_q  <= nrst_d;
    end
  // capture in IDLE, decode in APPLY, then WAIT runs WRITE_CYCLES-1 cycles so ready is low WRITE_CYCLES cycles
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    attn_d  = attn_q;
    tone_d  = tone_q;
    noise_d = noise_q;
    nrst_d  = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d  = bus.wr ? bus.data : hold_q;
        state_d = bus.wr ? APPLY : IDLE;
      end
      APPLY: begin
        ptr_d   = hold_q[7] ? hold_q[6:4] : ptr_q;
        cnt_d   = 8'(WRITE_CYCLES - 2);
        state_d = WAIT;
        if (vol)
          attn_d[{ch, 2'b00} +: 4] = hold_q[3:0];
        else if (ch == 2'd3) begin
          noise_d = hold_q[2:0];
          nrst_d  = 1'b1;
        end else
          for (int i = 0; i < 3; i++)
            if (ch == 2'(i))
              tone_d[10*i +: 10] = hold_q[7] ? {tone_q[10*i+4 +: 6], hold_q[3:0]}
                                             : {hold_q[5:0], tone_q[10*i +: 4]};
      end
      WAIT: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_psg_bus_controller.sv
// tb_psg_bus_controller: randomized and directed checks against a register-map model
module tb_psg_bus_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic wr = 1'b0;
  logic [7:0] data = '0;
  int wc = 4;
  int total = 0;
  int bad = 0;
  int np = 0;
  logic [3:0] m_attn[4];
  logic [9:0] m_tone[3];
  logic [2:0] m_noise;
  logic [1:0] m_ch;
  logic m_vol;
  int m_pulses = 0;
  logic rdy;

  always #5 clk = ~clk;

  psg_bus_controller_if b4();
  psg_bus_controller_if b2();
  psg_bus_controller #(.WRITE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  psg_bus_controller #(.WRITE_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b4.wr   = wr & ~sel;
  assign b4.data = data;
  assign b2.wr   = wr & sel;
  assign b2.data = data;
  assign rdy     = sel ? b2.ready : b4.ready;

  always @(posedge clk) if (b4.noise_reset === 1'b1) np++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_attn[i] = 4'hF;
    for (int i = 0; i < 3; i++) m_tone[i] = '0;
    m_noise = '0;
    m_ch = 2'd0;
    m_vol = 1'b0;
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b[7]) begin
      m_ch = b[6:5];
      m_vol = b[4];
    end
    if (m_vol) m_attn[m_ch] = b[3:0];
    else if (m_ch == 2'd3) begin
      m_noise = b[2:0];
      m_pulses++;
    end else if (b[7]) m_tone[m_ch] = (m_tone[m_ch] & 10'h3F0) | 10'(b[3:0]);
    else m_tone[m_ch] = (m_tone[m_ch] & 10'h00F) | (10'(b[5:0]) << 4);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_attn"}, b4.attn, {m_attn[3], m_attn[2], m_attn[1], m_attn[0]});
    chk({tag, "_tone"}, b4.tone_freq, {m_tone[2], m_tone[1], m_tone[0]});
    chk({tag, "_noise"}, b4.noise_ctrl, m_noise);
    chk({tag, "_pulses"}, np, m_pulses);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    int n;
    wait_ready(n);
    data = b;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    wait_ready(n);
    chk("busy_len", n, wc);
    if (!sel) m_apply(b);
  endtask

  task automatic hold(input logic [7:0] b, input int k);
    int acc, run;
    wait_ready(run);
    data = b;
    wr = 1'b1;
    acc = 0;
    run = 0;
    for (int i = 0; i < k; i++) begin
      if (rdy) begin
        acc++;
        if (run > 0) chk("hold_busy", run, wc);
        run = 0;
      end else run++;
      @(negedge clk);
    end
    wr = 1'b0;
    while (!rdy && run < 50) begin
      run++;
      @(negedge clk);
    end
    if (run > 0) chk("hold_busy_last", run, wc);
    chk("hold_accepts", acc, (k + wc) / (wc + 1));
    if (!sel) for (int i = 0; i < acc; i++) m_apply(b);
  endtask

  initial begin
    int n;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready4", b4.ready, 1);
    chk("rst_ready2", b2.ready, 1);
    chk("rst_attn", b4.attn, 16'hFFFF);
    chk("rst_tone", b4.tone_freq, 0);
    chk("rst_noise", b4.noise_ctrl, 0);
    chk("rst_nreset", b4.noise_reset, 0);
    wr_byte(8'h8E);
    wr_byte(8'h0F);
    chk("tone_two", b4.tone_freq[9:0], 10'h0FE);
    wr_byte(8'h3F);
    chk("tone_hi", b4.tone_freq[9:0], 10'h3FE);
    check_regs("tone");
    wr_byte(8'h9A);
    wr_byte(8'hB5);
    wr_byte(8'hD0);
    wr_byte(8'hF7);
    chk("vol_all", b4.attn, 16'h705A);
    wr_byte(8'h43);
    chk("vol_data", b4.attn, 16'h305A);
    check_regs("vol");
    n = np;
    wr_byte(8'hE5);
    chk("noise_latch", b4.noise_ctrl, 3'b101);
    chk("noise_pulse1", np, n + 1);
    wr_byte(8'h06);
    chk("noise_data", b4.noise_ctrl, 3'b110);
    chk("noise_pulse2", np, n + 2);
    wr_byte(8'hF2);
    chk("noise_vol_nopulse", np, n + 2);
    check_regs("noise");
    hold(8'h9A, 12);
    check_regs("hold9a");
    wait_ready(n);
    data = 8'h9A;
    wr = 1'b1;
    @(negedge clk);
    data = 8'hBF;
    repeat (2) @(negedge clk);
    wr = 1'b0;
    wait_ready(n);
    m_apply(8'h9A);
    check_regs("dropped");
    wr_byte(8'hE0);
    hold(8'h06, 14);
    check_regs("hold_noise");
    sel = 1'b1;
    wc = 2;
    hold(8'h9A, 9);
    chk("wc2_attn", b2.attn[3:0], 4'hA);
    sel = 1'b0;
    wc = 4;
    wr_byte(8'hE5);
    wait_ready(n);
    data = 8'hE5;
    wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", b4.ready, 1);
    chk("abort_noise", b4.noise_ctrl, 0);
    chk("abort_pulses", np, m_pulses);
    m_reset();
    wr_byte(8'h01);
    chk("abort_ptr", b4.tone_freq[9:0], 10'h010);
    check_regs("abort");
    for (int i = 0; i < 200; i++) begin
      wr_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      check_regs("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
